stepper_sequencer: RTL and testbench

//  Drives the 4-wire unipolar stepper on JA1..JA4 from the processor's

---
 rtl/stepper_sequencer_pkg.sv | 35 +++
 rtl/stepper_sequencer_step_rate_timer.sv | 51 +++++
 rtl/stepper_sequencer.sv | 112 +++++++++++
 tb/tb_stepper_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_sequencer_pkg.sv
// Shared definitions for the stepper sequencer: controller states and the
// 8-entry coil phase table used by the drive logic.
package stepper_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // {A,B,A',B'} energisation for phase index 0..7
    function automatic logic [3:0] phase_coil(input logic [2:0] idx);
        logic [3:0] pattern;
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
        return pattern;
    endfunction

    function automatic logic [2:0] phase_advance(input logic [2:0] idx,
                                                 input logic       fwd,
                                                 input logic       half);
        logic [2:0] inc;
        inc = half ? 3'd1 : 3'd2;
        return fwd ? idx + inc : idx - inc;
    endfunction

endpackage

// File: rtl/stepper_sequencer_step_rate_timer.sv
// Step period register with linear saturating ramp, plus the down-counter
// whose zero cycle marks a step event.
module step_rate_timer
    import stepper_sequencer_pkg::*;
#(
    parameter int unsigned START_PERIOD = 500_000,
    parameter int unsigned MIN_PERIOD   = 50_000,
    parameter int unsigned RAMP_DEC     = 5_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic step,
    input  logic restart,
    input  logic count,
    output logic tick
);

    localparam logic [32:0] RAMP_FLOOR = 33'(MIN_PERIOD) + 33'(RAMP_DEC);

    logic [31:0] period;
    logic [31:0] timer;
    logic [31:0] next_period;

    // Compare before subtracting so a large RAMP_DEC cannot wrap the period
    always_comb begin
        next_period = 32'(MIN_PERIOD);
        if (restart)
            next_period = 32'(START_PERIOD);
        else if ({1'b0, period} >= RAMP_FLOOR)
            next_period = period - 32'(RAMP_DEC);
    end

    assign tick = (timer == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period <= 32'(START_PERIOD);
            timer  <= '0;
        end else if (load) begin
            period <= 32'(START_PERIOD);
            timer  <= 32'(START_PERIOD) - 32'd1;
        end else if (step) begin
            period <= next_period;
            timer  <= next_period - 32'd1;
        end else if (count && !tick) begin
            timer  <= timer - 32'd1;
        end
    end

endmodule

// File: rtl/stepper_sequencer.sv
// Unipolar stepper driver: run/dir control, ramped step timing, wave or
// half-step coil sequencing and a wrapping signed position count.
module stepper_sequencer
    import stepper_sequencer_pkg::*;
#(
    parameter int unsigned START_PERIOD = 500_000,
    parameter int unsigned MIN_PERIOD   = 50_000,
    parameter int unsigned RAMP_DEC     = 5_000,
    parameter bit          HALF_STEP    = 1'b1,
    parameter bit          HOLD_ENABLE  = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        dir,
    output logic [3:0]  coil,
    output logic        busy,
    output logic        step_pulse,
    output logic [31:0] position
);

    state_t     state;
    logic       dir_q;
    logic [2:0] phase;
    logic [2:0] next_phase;
    logic [3:0] idle_coil;
    logic       tick;
    logic       load;
    logic       step;
    logic       restart;
    logic       count;

    // A pending period that expires while run is low returns straight to IDLE
    always_comb begin
        next_phase = phase_advance(phase, dir, HALF_STEP);
        idle_coil  = HOLD_ENABLE ? phase_coil(phase) : '0;
        step       = (state == RUN) && run && tick;
        restart    = (dir != dir_q);
        count      = (state != IDLE);
        load       = ((state == IDLE) && run) ||
                     (tick && ((state == DRAIN) || ((state == RUN) && !run)));
    end

    step_rate_timer #(
        .START_PERIOD (START_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD),
        .RAMP_DEC     (RAMP_DEC)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .restart (restart),
        .count   (count),
        .tick    (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            coil       <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            position   <= '0;
            phase      <= '0;
            dir_q      <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                        dir_q <= dir;
                        busy  <= 1'b1;
                        coil  <= phase_coil(phase);
                    end else begin
                        busy  <= 1'b0;
                        coil  <= idle_coil;
                    end
                end
                RUN: begin
                    if (!run) begin
                        if (tick) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            coil  <= idle_coil;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (tick) begin
                        dir_q      <= dir;
                        phase      <= next_phase;
                        coil       <= phase_coil(next_phase);
                        position   <= dir ? position + 32'd1 : position - 32'd1;
                        step_pulse <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        coil  <= idle_coil;
                    end else if (run) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: directed scenarios plus a
// randomized run/dir sequence checked against a schedule-based model.
module tb_stepper_sequencer;

    localparam int SP = 10;
    localparam int MP = 4;
    localparam int RD = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run   = 1'b0;
    logic        dir   = 1'b0;
    logic        run_w = 1'b0;
    logic [3:0]  coil, coil_w;
    logic        busy, busy_w;
    logic        step_pulse, step_pulse_w;
    logic [31:0] position, position_w;

    int total = 0;
    int bad   = 0;

    logic [3:0] ref_table [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};

    always #5 clock = ~clock;

    stepper_sequencer #(
        .START_PERIOD (SP),
        .MIN_PERIOD   (MP),
        .RAMP_DEC     (RD),
        .HALF_STEP    (1'b1),
        .HOLD_ENABLE  (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .dir        (dir),
        .coil       (coil),
        .busy       (busy),
        .step_pulse (step_pulse),
        .position   (position)
    );

    stepper_sequencer #(
        .START_PERIOD (SP),
        .MIN_PERIOD   (MP),
        .RAMP_DEC     (RD),
        .HALF_STEP    (1'b0),
        .HOLD_ENABLE  (1'b0)
    ) dut_wave (
        .clock      (clock),
        .reset      (reset),
        .run        (run_w),
        .dir        (dir),
        .coil       (coil_w),
        .busy       (busy_w),
        .step_pulse (step_pulse_w),
        .position   (position_w)
    );

    // Returns #1 after a rising edge with reset released: that is cycle 0
    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        run_w = 1'b0;
        dir   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        dir   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (coil !== 4'b0000) begin bad++; $display("FAIL reset_coil: got %b want 0000", coil); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (step_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", step_pulse); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_position: got %h want 0", position); end
    endtask

    // Forward ramp: pulses at 11,18,22,26,30; leaves the motor running at min period
    task automatic test_ramp();
        int         pc [5] = '{11, 18, 22, 26, 30};
        logic [3:0] cv [5] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
        int         idx = 0;
        logic       exp_p;
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            exp_p = (idx < 5) && (k == pc[idx]);
            total++; if (step_pulse !== exp_p) begin bad++; $display("FAIL ramp_pulse c%0d: got %b want %b", k, step_pulse, exp_p); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy c%0d: got %b want 1", k, busy); end
            if (k == 1) begin
                total++; if (coil !== 4'b1000) begin bad++; $display("FAIL ramp_first_coil: got %b want 1000", coil); end
            end
            if (exp_p) begin
                total++; if (coil !== cv[idx]) begin bad++; $display("FAIL ramp_coil #%0d: got %b want %b", idx, coil, cv[idx]); end
                total++; if (position !== 32'(idx + 1)) begin bad++; $display("FAIL ramp_position #%0d: got %h want %h", idx, position, idx + 1); end
                idx++;
            end
        end
    endtask

    // Reversal mid-period at min speed: old spacing, then ramp restarts 10,7,4
    task automatic test_reversal();
        int         pc [4] = '{34, 44, 51, 55};
        logic [3:0] cv [4] = '{4'b0010, 4'b0110, 4'b0100, 4'b1100};
        int         idx = 0;
        logic       exp_p;
        for (int k = 31; k <= 55; k++) begin
            @(posedge clock); #1;
            exp_p = (idx < 4) && (k == pc[idx]);
            total++; if (step_pulse !== exp_p) begin bad++; $display("FAIL rev_pulse c%0d: got %b want %b", k, step_pulse, exp_p); end
            if (exp_p) begin
                total++; if (coil !== cv[idx]) begin bad++; $display("FAIL rev_coil #%0d: got %b want %b", idx, coil, cv[idx]); end
                total++; if (position !== 32'(4 - idx)) begin bad++; $display("FAIL rev_position #%0d: got %h want %h", idx, position, 4 - idx); end
                idx++;
            end
            if (k == 32) dir = 1'b0;
        end
    endtask

    task automatic test_reverse_wrap();
        logic exp_p;
        do_reset();
        run = 1'b1;
        dir = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clock); #1;
            exp_p = (k == 11) || (k == 18);
            total++; if (step_pulse !== exp_p) begin bad++; $display("FAIL wrap_pulse c%0d: got %b want %b", k, step_pulse, exp_p); end
            if (k == 11) begin
                total++; if (coil !== 4'b1001) begin bad++; $display("FAIL wrap_coil1: got %b want 1001", coil); end
                total++; if (position !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_position1: got %h want ffffffff", position); end
            end
            if (k == 18) begin
                total++; if (coil !== 4'b0001) begin bad++; $display("FAIL wrap_coil2: got %b want 0001", coil); end
                total++; if (position !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_position2: got %h want fffffffe", position); end
            end
        end
    endtask

    // Drop run two cycles after the pulse at 18; re-assert at cycle 25
    task automatic test_drain();
        logic       exp_p, exp_b;
        logic [3:0] exp_c;
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            exp_p = (k == 11) || (k == 18) || (k == 36);
            exp_b = (k <= 21) || (k >= 26);
            exp_c = (k <= 10) ? 4'b1000 : (k <= 17) ? 4'b1100 : (k <= 21) ? 4'b0100 :
                    (k <= 25) ? 4'b0000 : (k <= 35) ? 4'b0100 : 4'b0110;
            total++; if (step_pulse !== exp_p) begin bad++; $display("FAIL drain_pulse c%0d: got %b want %b", k, step_pulse, exp_p); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL drain_busy c%0d: got %b want %b", k, busy, exp_b); end
            total++; if (coil !== exp_c) begin bad++; $display("FAIL drain_coil c%0d: got %b want %b", k, coil, exp_c); end
            if (k == 36) begin
                total++; if (position !== 32'd3) begin bad++; $display("FAIL drain_position: got %h want 3", position); end
            end
            if (k == 20) run = 1'b0;
            if (k == 25) run = 1'b1;
        end
    endtask

    task automatic test_wave();
        int         pc [4] = '{11, 18, 22, 26};
        logic [3:0] cv [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        int         idx = 0;
        logic       exp_p;
        do_reset();
        run_w = 1'b1;
        dir   = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clock); #1;
            exp_p = (idx < 4) && (k == pc[idx]);
            total++; if (step_pulse_w !== exp_p) begin bad++; $display("FAIL wave_pulse c%0d: got %b want %b", k, step_pulse_w, exp_p); end
            if (k == 1) begin
                total++; if (coil_w !== 4'b1000) begin bad++; $display("FAIL wave_first_coil: got %b want 1000", coil_w); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL wave_main_idle: got %b want 0", busy); end
            end
            if (exp_p) begin
                total++; if (coil_w !== cv[idx]) begin bad++; $display("FAIL wave_coil #%0d: got %b want %b", idx, coil_w, cv[idx]); end
                total++; if (position_w !== 32'(idx + 1)) begin bad++; $display("FAIL wave_position #%0d: got %h want %h", idx, position_w, idx + 1); end
                idx++;
            end
        end
        run_w = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        repeat (20) @(posedge clock);
        #4;
        reset = 1'b1;
        #1;
        total++; if (coil !== 4'b0000) begin bad++; $display("FAIL async_coil: got %b want 0000", coil); end
        total++; if (position !== 32'd0) begin bad++; $display("FAIL async_position: got %h want 0", position); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        run   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_idle_busy c%0d: got %b want 0", k, busy); end
        end
        run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); #1;
            if (k == 11) begin
                total++; if (step_pulse !== 1'b1) begin bad++; $display("FAIL async_restart_pulse: got %b want 1", step_pulse); end
                total++; if (coil !== 4'b1100) begin bad++; $display("FAIL async_restart_coil: got %b want 1100", coil); end
                total++; if (position !== 32'd1) begin bad++; $display("FAIL async_restart_position: got %h want 1", position); end
            end
        end
    endtask

    // Model schedules step events by absolute cycle number
    task automatic test_random();
        int          m_st = 0;
        int          m_due = 0;
        int          m_period = SP;
        int          m_phase = 0;
        logic [31:0] m_pos = '0;
        logic        m_dirq = 1'b0;
        logic        m_pulse;
        logic        exp_b;
        logic [3:0]  exp_c;
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (c > 0 && $urandom_range(0, 14) == 0) run = ~run;
            if ($urandom_range(0, 11) == 0) dir = ~dir;
            @(posedge clock);
            m_pulse = 1'b0;
            if (m_st == 0) begin
                if (run) begin
                    m_st = 1; m_dirq = dir; m_period = SP; m_due = c + SP;
                end
            end else if (m_st == 1) begin
                if (!run) begin
                    if (c == m_due) begin m_st = 0; m_period = SP; end
                    else m_st = 2;
                end else if (c == m_due) begin
                    if (dir != m_dirq) m_period = SP;
                    else m_period = (m_period - RD < MP) ? MP : m_period - RD;
                    m_dirq  = dir;
                    m_phase = (m_phase + (dir ? 1 : 7)) % 8;
                    m_pos   = m_pos + (dir ? 32'd1 : 32'hFFFF_FFFF);
                    m_pulse = 1'b1;
                    m_due   = c + m_period;
                end
            end else begin
                if (c == m_due) begin m_st = 0; m_period = SP; end
                else if (run) m_st = 1;
            end
            #1;
            exp_b = (m_st != 0);
            exp_c = (m_st == 0) ? 4'b0000 : ref_table[m_phase];
            total++; if (step_pulse !== m_pulse) begin bad++; $display("FAIL rnd_pulse c%0d: got %b want %b", c, step_pulse, m_pulse); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, exp_b); end
            total++; if (coil !== exp_c) begin bad++; $display("FAIL rnd_coil c%0d: got %b want %b", c, coil, exp_c); end
            total++; if (position !== m_pos) begin bad++; $display("FAIL rnd_position c%0d: got %h want %h", c, position, m_pos); end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_reversal();
        test_reverse_wrap();
        test_drain();
        test_wave();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
